tlb_inv_seq: RTL and testbench
==============================

Name: tlb_inv_seq

Overview:
- Multi-cycle INVTLB sequencer.
- Walks every TLB entry through the shared TLB read port, evaluates the LoongArch INVTLB match rule, and issues a write that clears E on each matching valid entry.
- Sits beside the write-back stage: WB launches the request after commit and stalls (wb_allowin low) while busy.
- WB's own TLBRD/TLBWR/TLBFILL accesses take priority on the shared ports.

Parameters:
- TLBNUM, 16, number of TLB entries (power of two).
- IDX_W, 4, log2(TLBNUM).

Ports:
- clk, input, 1, clock.
- resetn, input, 1, synchronous active-low reset.
- req_valid, input, 1, INVTLB request from WB (committed, never cancelled).
- req_ready, output, 1, high in IDLE only.
- req_op, input, 5, INVTLB op field.
- req_asid, input, 10, rj[9:0].
- req_vppn, input, 19, rk[31:13].
- busy, output, 1, request held or walk in progress; WB stalls on it.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, one-cycle pulse with done when op>6.
- port_hold, input, 1, WB owns the TLB ports this cycle.
- r_index, output, IDX_W, TLB read-port index (muxed onto the port by top while busy).
- r_e / r_vppn / r_ps / r_asid / r_g, input, 1/19/6/10/1, combinational read-port result for r_index.
- inv_we, output, 1, write strobe: clear E of entry inv_index.
- inv_index, output, IDX_W, entry to invalidate.

Behaviour:
- Reset: state=IDLE, idx=0, req_ready=1, busy=0, done=0, err=0, inv_we=0, r_index=0.
- Reset mid-walk aborts immediately. Entries already cleared stay cleared; nothing else is written.
- Handshake: accept on req_valid & req_ready. Latch op/asid/vppn into registers; later changes on the req_* inputs are ignored.
- FSM states:
  - IDLE:
    - On accept with op<=6: go WALK, idx=0.
    - On accept with op>6: go DONE with err flag set.
  - WALK, each cycle:
    - port_hold=1: idx holds, inv_we=0, no evaluation.
    - Else: r_index=idx; compute match; inv_we = r_e & match; inv_index=idx.
    - If idx==TLBNUM-1, go DONE; else idx+1.
  - DONE: done=1 for one cycle (err=1 if flagged); clear flag; return to IDLE.
- busy = (state!=IDLE) | req_valid.
- Latency without holds: done asserts TLBNUM+1 cycles after accept (17 for default). Each hold cycle adds 1.
- vppn compare:
  - r_ps==21: compare r_vppn[18:9] only.
  - Otherwise: full 19 bits.
- asid_m = (r_asid==asid).
- match by op:
  - 0,1: 1.
  - 2: g.
  - 3: ~g.
  - 4: ~g & asid_m.
  - 5: ~g & asid_m & vppn_m.
  - 6: (g | asid_m) & vppn_m.
- inv_we is never asserted in the same cycle as port_hold. Top arbiter guarantees WB writes never collide.
- Back-to-back requests: req_ready rises in the cycle after DONE, so the minimum issue interval is TLBNUM+2 cycles.
- Index wrap: idx is IDX_W bits. Termination uses the explicit TLBNUM-1 compare, never overflow.

Decomposition:
- Shared package/macros header:
  - INVTLB op constants (INV_ALL0, INV_ALL1, INV_G, INV_NG, INV_NG_ASID, INV_NG_ASID_VA, INV_GA_VA).
  - State encodings (TIS_IDLE/WALK/DONE).
  - PS_4M=21 constant.
- One sub-module: tlb_inv_match. Purely combinational; inputs op, asid, vppn and the entry fields; output match.

Test Plan:
- Op 0, 16 entries all E=1 -> inv_we on idx 0..15 consecutively; done at cycle 17 after accept; err=0.
- Op 3, even entries G=1, odd G=0 -> inv_we only on odd indices (8 pulses); even entries untouched.
- Op 5, asid=0x012, vppn=0x12345. Entry 4 matches (G=0, ps=12). Entry 9 has ASID 0x013. Entry 11 has ps=21, vppn 0x123FF -> invalidates 4 and 11 only.
- Op 6, entry 2 G=1 with ASID 0x3FF and matching vppn -> entry 2 cleared. Entry 7 G=0, ASID mismatch -> kept.
- port_hold high for 3 cycles at idx 5 -> no inv_we during hold; idx resumes at 5; done at cycle 20.
- Op 7 -> done=err=1 one cycle after accept, no inv_we. Separately: resetn low at idx 8 -> next cycle IDLE, req_ready=1, no further writes.

Source files
------------

// File: rtl/tlb_inv_seq_pkg.sv
// tlb_inv_seq_pkg
//   Shared constants and types for the INVTLB sequencer:
//   - INVTLB op codes (0..6 are defined; anything larger is illegal)
//   - sequencer state encodings
//   - page-size code of a 4 MB page
//   - the latched request record
package tlb_inv_seq_pkg;

  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G          = 5'd2;
  localparam logic [4:0] INV_NG         = 5'd3;
  localparam logic [4:0] INV_NG_ASID    = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA      = 5'd6;

  localparam logic [1:0] TIS_IDLE = 2'd0;
  localparam logic [1:0] TIS_WALK = 2'd1;
  localparam logic [1:0] TIS_DONE = 2'd2;

  localparam logic [5:0] PS_4M = 6'd21;

  typedef struct packed {
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [18:0] vppn;
  } inv_req_t;

  // Ops above INV_GA_VA complete immediately with an error flag.
  function automatic logic op_illegal(input logic [4:0] op);
    return op > INV_GA_VA;
  endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// tlb_inv_match
//   Combinational INVTLB match rule for one TLB entry.
//   Ports:
//     op, asid, vppn        : latched INVTLB request fields
//     e_vppn, e_ps, e_asid,
//     e_g                   : fields of the entry being examined
//     match                 : entry is selected by this op (E is not considered here)
module tlb_inv_match
  import tlb_inv_seq_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [9:0]  asid,
  input  logic [18:0] vppn,
  input  logic [18:0] e_vppn,
  input  logic [5:0]  e_ps,
  input  logic [9:0]  e_asid,
  input  logic        e_g,
  output logic        match
);

  logic asid_m;
  logic vppn_m;

  assign asid_m = (e_asid == asid);

  // A 4 MB page only decodes the upper ten vppn bits; the rest are page offset.
  assign vppn_m = (e_ps == PS_4M) ? (e_vppn[18:9] == vppn[18:9])
                                  : (e_vppn == vppn);

  always_comb begin
    match = 1'b0;
    case (op)
      INV_ALL0, INV_ALL1: match = 1'b1;
      INV_G:              match = e_g;
      INV_NG:             match = ~e_g;
      INV_NG_ASID:        match = ~e_g & asid_m;
      INV_NG_ASID_VA:     match = ~e_g & asid_m & vppn_m;
      INV_GA_VA:          match = (e_g | asid_m) & vppn_m;
      default:            match = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_inv_seq.sv
// tlb_inv_seq
//   Multi-cycle INVTLB sequencer. Walks every TLB entry through the shared
//   read port and clears E on each valid entry that matches the request.
//   Ports:
//     clk, resetn               : clock, synchronous active-low reset
//     req_valid/req_ready       : request handshake from write-back
//     req_op/req_asid/req_vppn  : INVTLB op, rj[9:0], rk[31:13]
//     busy                      : write-back must stall while high
//     done, err                 : one-cycle completion pulse, err for op>6
//     port_hold                 : write-back owns the TLB ports this cycle
//     r_index, r_e..r_g         : shared TLB read port (index out, fields in)
//     inv_we, inv_index         : clear-E write strobe and target entry
module tlb_inv_seq
  import tlb_inv_seq_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [9:0]       req_asid,
  input  logic [18:0]      req_vppn,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             port_hold,
  output logic [IDX_W-1:0] r_index,
  input  logic             r_e,
  input  logic [18:0]      r_vppn,
  input  logic [5:0]       r_ps,
  input  logic [9:0]       r_asid,
  input  logic             r_g,
  output logic             inv_we,
  output logic [IDX_W-1:0] inv_index
);

  // Termination is an explicit compare so the walk never relies on wrap.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

  logic [1:0]       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  inv_req_t         req_reg, req_next;
  logic             err_reg, err_next;
  logic             accept;
  logic             match;
  logic             eval;

  assign accept = req_valid & (state_reg == TIS_IDLE);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    req_next   = req_reg;
    err_next   = err_reg;
    case (state_reg)
      TIS_IDLE: begin
        if (accept) begin
          req_next = '{op: req_op, asid: req_asid, vppn: req_vppn};
          idx_next = '0;
          if (op_illegal(req_op)) begin
            state_next = TIS_DONE;
            err_next   = 1'b1;
          end else begin
            state_next = TIS_WALK;
          end
        end
      end
      TIS_WALK: begin
        // A hold cycle freezes the walk: the port result belongs to write-back.
        if (!port_hold) begin
          if (idx_reg == LAST_IDX) begin
            state_next = TIS_DONE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      TIS_DONE: begin
        state_next = TIS_IDLE;
        err_next   = 1'b0;
      end
      default: begin
        state_next = TIS_IDLE;
        err_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= TIS_IDLE;
      idx_reg   <= '0;
      req_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      req_reg   <= req_next;
      err_reg   <= err_next;
    end
  end

  tlb_inv_match u_match (
    .op     (req_reg.op),
    .asid   (req_reg.asid),
    .vppn   (req_reg.vppn),
    .e_vppn (r_vppn),
    .e_ps   (r_ps),
    .e_asid (r_asid),
    .e_g    (r_g),
    .match  (match)
  );

  assign eval      = (state_reg == TIS_WALK) & ~port_hold;
  assign r_index   = idx_reg;
  assign inv_index = idx_reg;

  // Gating the strobes with resetn makes a mid-walk reset abort in the same
  // cycle: the entry under evaluation is left untouched.
  assign inv_we    = resetn & eval & r_e & match;
  assign done      = resetn & (state_reg == TIS_DONE);
  assign err       = done & err_reg;
  assign req_ready = (state_reg == TIS_IDLE);
  assign busy      = (state_reg != TIS_IDLE) | req_valid;

endmodule

// File: tb/tb_tlb_inv_seq.sv
module tb_tlb_inv_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [9:0]  req_asid = '0;
  logic [18:0] req_vppn = '0;
  logic        busy, done, err;
  logic        port_hold = 1'b0;
  logic [3:0]  r_index;
  logic        r_e;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic        r_g;
  logic        inv_we;
  logic [3:0]  inv_index;

  always #5 clk = ~clk;

  tlb_inv_seq #(.TLBNUM(16), .IDX_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_asid(req_asid), .req_vppn(req_vppn),
    .busy(busy), .done(done), .err(err), .port_hold(port_hold),
    .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps),
    .r_asid(r_asid), .r_g(r_g),
    .inv_we(inv_we), .inv_index(inv_index)
  );

  // ---------------- bench-side TLB ----------------
  logic [15:0] tb_e = '0;
  logic [18:0] tb_vppn [16];
  logic [5:0]  tb_ps   [16];
  logic [9:0]  tb_asid [16];
  logic        tb_g    [16];
  logic        e_load = 1'b0;
  logic [15:0] e_load_val = '0;

  always @(posedge clk) begin
    if (e_load) tb_e <= e_load_val;
    else if (inv_we) tb_e[inv_index] <= 1'b0;
  end

  assign r_e    = tb_e[r_index];
  assign r_vppn = tb_vppn[r_index];
  assign r_ps   = tb_ps[r_index];
  assign r_asid = tb_asid[r_index];
  assign r_g    = tb_g[r_index];

  // ---------------- reference model ----------------
  function automatic bit rule(input int op, input bit [9:0] a, input bit [18:0] v, input int i);
    bit va_m, as_m, g;
    va_m = (tb_ps[i] == 6'd21) ? ((tb_vppn[i] >> 9) == (v >> 9)) : (tb_vppn[i] == v);
    as_m = (tb_asid[i] == a);
    g    = tb_g[i];
    case (op)
      0, 1:    return 1'b1;
      2:       return g;
      3:       return !g;
      4:       return !g && as_m;
      5:       return !g && as_m && va_m;
      6:       return (g || as_m) && va_m;
      default: return 1'b0;
    endcase
  endfunction

  int m_phase = 0;   // 0 idle, 1 walking, 2 completing
  int m_pos = 0;
  bit m_err = 1'b0;
  bit m_exp [16];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn) begin
      m_phase <= 0; m_pos <= 0; m_err <= 1'b0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          if (req_op > 5'd6) begin
            m_phase <= 2; m_err <= 1'b1;
          end else begin
            m_phase <= 1; m_pos <= 0;
            for (int i = 0; i < 16; i++)
              m_exp[i] <= tb_e[i] && rule(int'(req_op), req_asid, req_vppn, i);
          end
        end
        1: if (!port_hold) begin
          if (m_pos == 15) m_phase <= 2;
          else m_pos <= m_pos + 1;
        end
        default: begin m_phase <= 0; m_err <= 1'b0; end
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  bit err_seen = 1'b0;
  int acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_loop();
    bit exp_we;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk("rst_inv_we", 32'(inv_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
      end else begin
        exp_we = (m_phase == 1) && !port_hold && m_exp[m_pos];
        chk("req_ready", 32'(req_ready), 32'(m_phase == 0));
        chk("busy", 32'(busy), 32'((m_phase != 0) || req_valid));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("err", 32'(err), 32'((m_phase == 2) && m_err));
        chk("inv_we", 32'(inv_we), 32'(exp_we));
        if (m_phase == 1) chk("r_index", 32'(r_index), 32'(m_pos));
        if (exp_we) chk("inv_index", 32'(inv_index), 32'(m_pos));
        if (inv_we) pulse_cnt++;
        if (err) err_seen = 1'b1;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic fill_all(input bit g, input logic [9:0] a, input logic [18:0] v, input logic [5:0] ps);
    for (int i = 0; i < 16; i++) begin
      tb_g[i] = g; tb_asid[i] = a; tb_vppn[i] = v; tb_ps[i] = ps;
    end
  endtask

  task automatic set_ent(input int i, input bit g, input logic [9:0] a, input logic [18:0] v, input logic [5:0] ps);
    tb_g[i] = g; tb_asid[i] = a; tb_vppn[i] = v; tb_ps[i] = ps;
  endtask

  task automatic load_e(input logic [15:0] v);
    @(posedge clk); #1;
    e_load = 1'b1; e_load_val = v;
    @(posedge clk); #1;
    e_load = 1'b0;
  endtask

  // Returns #1 after the accepting edge; request fields are then scrambled.
  task automatic issue(input logic [4:0] op, input logic [9:0] a, input logic [18:0] v);
    int k;
    pulse_cnt = 0; err_seen = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_asid = a; req_vppn = v;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (k == 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    req_op = 5'($urandom); req_asid = 10'($urandom); req_vppn = 19'($urandom);
  endtask

  task automatic wait_done(input bit rnd, output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin lat = cyc - acc_cyc + 1; break; end
      @(posedge clk); #1;
      if (rnd) port_hold = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    port_hold = 1'b0;
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic stimulus();
    int lat;
    logic [9:0]  asids [4];
    logic [18:0] vppns [3];
    asids[0] = 10'h012; asids[1] = 10'h013; asids[2] = 10'h3FF; asids[3] = 10'h100;
    vppns[0] = 19'h12345; vppns[1] = 19'h123FF; vppns[2] = 19'h00000;

    // reset state
    fill_all(1'b0, 10'h0, 19'h0, 6'd12);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_inv_we", 32'(inv_we), 32'd0);
    chk("reset_r_index", 32'(r_index), 32'd0);
    resetn = 1'b1;

    // op 0, all valid
    load_e(16'hFFFF);
    issue(5'd0, 10'h0, 19'h0);
    wait_done(1'b0, lat);
    chk("op0_latency", 32'(lat), 32'd17);
    chk("op0_pulses", 32'(pulse_cnt), 32'd16);
    chk("op0_err", 32'(err_seen), 32'd0);
    chk("op0_e", 32'(tb_e), 32'h0000);

    // op 3, even entries global
    for (int i = 0; i < 16; i++) set_ent(i, (i % 2) == 0, 10'h0, 19'h0, 6'd12);
    load_e(16'hFFFF);
    issue(5'd3, 10'h0, 19'h0);
    wait_done(1'b0, lat);
    chk("op3_pulses", 32'(pulse_cnt), 32'd8);
    chk("op3_e", 32'(tb_e), 32'h5555);

    // op 5, asid/vppn match including a 4 MB page
    fill_all(1'b1, 10'h012, 19'h12345, 6'd12);
    set_ent(4,  1'b0, 10'h012, 19'h12345, 6'd12);
    set_ent(9,  1'b0, 10'h013, 19'h12345, 6'd12);
    set_ent(11, 1'b0, 10'h012, 19'h123FF, 6'd21);
    load_e(16'hFFFF);
    issue(5'd5, 10'h012, 19'h12345);
    wait_done(1'b0, lat);
    chk("op5_pulses", 32'(pulse_cnt), 32'd2);
    chk("op5_e", 32'(tb_e), 32'hF7EF);

    // op 6, global entry matches regardless of asid
    fill_all(1'b1, 10'h012, 19'h00000, 6'd12);
    set_ent(2, 1'b1, 10'h3FF, 19'h12345, 6'd12);
    set_ent(7, 1'b0, 10'h100, 19'h12345, 6'd12);
    load_e(16'hFFFF);
    issue(5'd6, 10'h012, 19'h12345);
    wait_done(1'b0, lat);
    chk("op6_pulses", 32'(pulse_cnt), 32'd1);
    chk("op6_e", 32'(tb_e), 32'hFFFB);

    // three hold cycles at idx 5
    load_e(16'hFFFF);
    issue(5'd0, 10'h0, 19'h0);
    repeat (5) @(posedge clk);
    #1; port_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1; port_hold = 1'b0;
    wait_done(1'b0, lat);
    chk("hold_latency", 32'(lat), 32'd20);
    chk("hold_pulses", 32'(pulse_cnt), 32'd16);
    chk("hold_e", 32'(tb_e), 32'h0000);

    // illegal op
    load_e(16'hFFFF);
    issue(5'd7, 10'h0, 19'h0);
    wait_done(1'b0, lat);
    chk("op7_latency", 32'(lat), 32'd1);
    chk("op7_err", 32'(err_seen), 32'd1);
    chk("op7_pulses", 32'(pulse_cnt), 32'd0);
    chk("op7_e", 32'(tb_e), 32'hFFFF);

    // reset while idx 8 is under evaluation
    issue(5'd0, 10'h0, 19'h0);
    repeat (8) @(posedge clk);
    #1; resetn = 1'b0;
    @(posedge clk);
    #1; resetn = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_e", 32'(tb_e), 32'hFF00);
    chk("abort_pulses", 32'(pulse_cnt), 32'd8);

    // randomized requests with random port holds
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++)
        set_ent(i, 1'($urandom), asids[$urandom_range(0, 3)],
                vppns[$urandom_range(0, 2)], ($urandom_range(0, 1) == 1) ? 6'd21 : 6'd12);
      load_e(16'($urandom));
      issue(5'($urandom_range(0, 9)), asids[$urandom_range(0, 3)], vppns[$urandom_range(0, 2)]);
      wait_done(1'b1, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    fork
      check_loop();
      stimulus();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
